shift_sequencer: RTL and testbench

Multi-cycle shift controller for the ALU shift path. Accepts a 32-bit operand, a 5-bit shift amount and a shift type. It then sequences one fixed power-of-two shift stage per cycle (16, 8, 4, 2, 1), applying or bypassing each stage according to the matching shift-amount bit. It sits beside the ALU and drives the shift result back onto the ALU result mux, with a start/busy/done handshake to the processor control.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_sequencer_if.sv | 21 ++
 rtl/shift_stage.sv | 34 +++
 rtl/shift_sequencer.sv | 85 ++++++++
 tb/tb_shift_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer:
// op encodings, FSM state type and the default datapath width.
package shift_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between processor control (master) and the
// shift sequencer (slave).
interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic                   start;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [1:0]             op;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  result;

  modport master (output start, data_in, shamt, op, input busy, done, result);
  modport slave  (input start, data_in, shamt, op, output busy, done, result);

endinterface

// File: rtl/shift_stage.sv
// Combinational single stage: shifts data by 2^idx according to op.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [1:0]             op,
  input  logic [SHAMT_WIDTH-1:0] idx,
  output logic [DATA_WIDTH-1:0]  out
);

  // One extra bit so that both 2^idx and DATA_WIDTH - 2^idx are representable.
  logic [SHAMT_WIDTH:0] amt;
  logic [SHAMT_WIDTH:0] rot_amt;

  assign amt     = (SHAMT_WIDTH+1)'(1) << idx;
  assign rot_amt = (SHAMT_WIDTH+1)'(DATA_WIDTH) - amt;

  // NOTE: the default assignment up front guarantees every path drives
  // out, so no latch can be inferred.
  always_comb begin
    out = data;
    case (op)
      OP_SLL:  out = data << amt;
      OP_SRL:  out = data >> amt;
      OP_SRA:  out = DATA_WIDTH'($signed(data) >>> amt);
      OP_ROR:  out = (data >> amt) | (data << rot_amt);
      default: out = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: walks stages 16,8,4,2,1 one per cycle,
// applying each stage when the matching shamt bit is set.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  shift_sequencer_if.slave bus
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  state_e                 state;
  logic [SHAMT_WIDTH-1:0] idx;
  logic [SHAMT_WIDTH-1:0] shamt_q;
  logic [1:0]             op_q;
  logic [DATA_WIDTH-1:0]  work;
  logic [DATA_WIDTH-1:0]  stage_out;
  logic                   busy_q;
  logic                   done_q;

  shift_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_stage (
    .data (work),
    .op   (op_q),
    .idx  (idx),
    .out  (stage_out)
  );

  // NOTE: every register here, including the datapath, is cleared on reset
  // so an aborted operation leaves no stale result visible.
  // NOTE: non-blocking assignments keep all flops updating from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      work    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new request directly for back-to-back throughput.
          if (bus.start) begin
            work    <= bus.data_in;
            shamt_q <= bus.shamt;
            op_q    <= bus.op;
            idx     <= SHAMT_WIDTH'(SHAMT_WIDTH - 1);
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end else begin
            state   <= IDLE;
          end
        end
        SHIFT: begin
          if (shamt_q[idx]) work <= stage_out;
          if (idx == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx    <= idx - 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table plus corner-case sequences and an all-op/all-shamt sweep
// for shift_sequencer, checked against hand values and a reference model.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  shift_sequencer_if #(.DATA_WIDTH(32)) bus ();

  shift_sequencer #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {d, d} >> s;
    case (o)
      OP_SLL:  return d << s;
      OP_SRL:  return d >> s;
      OP_SRA:  return 32'($signed(d) >>> s);
      default: return dbl[31:0];
    endcase
  endfunction

  // Drive a request, let it be accepted at E0, then scramble the inputs.
  task automatic accept(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    @(negedge clock);
    bus.op      = o;
    bus.data_in = d;
    bus.shamt   = s;
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.op      = 2'($urandom);
  endtask

  // Called #1 after the accept edge; lat = cycles from accept to done.
  task automatic wait_done(output int lat, output int bc);
    lat = 99;
    bc  = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) bc++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] d,
                     input logic [4:0] s, input logic [31:0] exp);
    int lat, bc;
    accept(o, d, s);
    wait_done(lat, bc);
    check({name, " result"}, bus.result, exp);
    check({name, " latency"}, lat, 5);
    check({name, " busy cycles"}, bc, 5);
    @(posedge clock);
    #1;
    check({name, " done pulse width"}, 32'(bus.done), 0);
    check({name, " result hold"}, bus.result, exp);
  endtask

  initial begin
    int lat, lat2, bc, dones;

    vecs[0]  = '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[1]  = '{OP_SRA, 32'h8000_0000, 5'd8,  32'hFF80_0000};
    vecs[2]  = '{OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[3]  = '{OP_SLL, 32'h0000_0001, 5'd17, 32'h0002_0000};
    vecs[4]  = '{OP_ROR, 32'h0000_00F1, 5'd4,  32'h1000_000F};
    vecs[5]  = '{OP_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[6]  = '{OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[7]  = '{OP_SRA, 32'h9234_5678, 5'd0,  32'h9234_5678};
    vecs[8]  = '{OP_ROR, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[9]  = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[10] = '{OP_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};
    vecs[11] = '{OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[12] = '{OP_SRL, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF};
    vecs[13] = '{OP_ROR, 32'h1234_5678, 5'd16, 32'h5678_1234};
    vecs[14] = '{OP_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.op      = OP_SLL;
    #2;
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset result", bus.result, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);

    // start pulsed while busy must not disturb the running operation
    accept(OP_SRL, 32'h8000_0000, 5'd4);
    fork
      begin
        @(negedge clock);
        bus.start   = 1'b1;
        bus.data_in = 32'hDEAD_BEEF;
        bus.shamt   = 5'd0;
        bus.op      = OP_SLL;
        repeat (3) @(negedge clock);
        bus.start   = 1'b0;
      end
      wait_done(lat, bc);
    join
    check("busy-start result", bus.result, 32'h0800_0000);
    check("busy-start latency", lat, 5);
    @(posedge clock);
    #1;
    check("busy-start no extra op", 32'(bus.busy), 0);

    // back-to-back: start held in the DONE cycle
    accept(OP_SLL, 32'h0000_0001, 5'd4);
    wait_done(lat, bc);
    check("b2b first result", bus.result, 32'h0000_0010);
    bus.op      = OP_SRL;
    bus.data_in = 32'h0000_0100;
    bus.shamt   = 5'd8;
    bus.start   = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("b2b no idle gap", 32'(bus.busy), 1);
    wait_done(lat2, bc);
    check("b2b done spacing", lat2 + 1, 6);
    check("b2b second result", bus.result, 32'h0000_0001);
    @(posedge clock);
    #1;

    // asynchronous reset in the third SHIFT cycle
    accept(OP_SRA, 32'h8000_0000, 5'd31);
    repeat (2) @(posedge clock);
    #3;
    check("pre-abort busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    check("abort result", bus.result, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    check("abort no done pulse", dones, 0);
    run("post-reset sll", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010);

    // sweep of every op and shift amount against the reference model
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 32; s++) begin
        logic [31:0] d;
        d = $urandom;
        if (s[0]) d[31] = 1'b1;
        run($sformatf("sweep op%0d sh%0d", o, s), 2'(o), d, 5'(s), ref_shift(2'(o), d, 5'(s)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
